// File: rtl/i2c_arb_pkg.sv
// Shared types and default phase timings for the i2c_master arbiter.
// The fixed-priority build option is I2C_ARB_FIXED_PRIO_EN (see i2c_master_arbiter).
package i2c_arb_pkg;

  typedef enum logic [2:0] {IDLE, START, HDR, DATA, STOP} arb_state_t;

  localparam int unsigned ADDR_PHASE_CYCLES_D = 9;
  localparam int unsigned BYTE_PHASE_CYCLES_D = 9;
  localparam int unsigned STOP_CYCLES_D       = 2;
  localparam int unsigned LEN_W               = 4;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Single-step modulo: v is always below 2*n at the call sites.
  function automatic int wrap_idx(int v, int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Combinational rotate-and-priority-encode: first set req bit at or after ptr, wrapping.
// FIXED_PRIO ignores ptr so the lowest set index always wins.
module i2c_arb_rr_pick import i2c_arb_pkg::*; #(
  parameter int unsigned N_REQ      = 4,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned IDX_W      = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] base;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    base       = FIXED_PRIO ? '0 : ptr;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!any && req[wrap_idx(int'(base) + i, int'(N_REQ))]) begin
        any = 1'b1;
        win_idx = IDX_W'(wrap_idx(int'(base) + i, int'(N_REQ)));
        win_onehot[wrap_idx(int'(base) + i, int'(N_REQ))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sequencing multi-byte transactions onto one i2c_master byte engine.
// Define I2C_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module i2c_master_arbiter import i2c_arb_pkg::*; #(
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned ADDR_PHASE_CYCLES = ADDR_PHASE_CYCLES_D,
  parameter int unsigned BYTE_PHASE_CYCLES = BYTE_PHASE_CYCLES_D,
  parameter int unsigned STOP_CYCLES       = STOP_CYCLES_D
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_rw,
  input  logic [7*N_REQ-1:0]     req_addr,
  input  logic [8*N_REQ-1:0]     req_wdata,
  input  logic [LEN_W*N_REQ-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       nxt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   m_start,
  output logic                   m_stop,
  output logic                   m_rw,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_wdata
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W =
      $clog2(max3(ADDR_PHASE_CYCLES, BYTE_PHASE_CYCLES, STOP_CYCLES) + 1);
`ifdef I2C_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] g_q, g_d, rr_q, rr_d;

  logic [N_REQ-1:0] gnt_q, gnt_d, nxt_q, nxt_d, done_q, done_d;
  logic             busy_q, busy_d, m_start_q, m_start_d, m_stop_q, m_stop_d, m_rw_q, m_rw_d;
  logic [6:0]       m_addr_q, m_addr_d;
  logic [7:0]       m_wdata_q, m_wdata_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [LEN_W-1:0] pick_len;

  i2c_arb_rr_pick #(
    .N_REQ      (N_REQ),
    .FIXED_PRIO (FIXED_PRIO),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (rr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

  assign pick_len = req_len[pick_idx*LEN_W +: LEN_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      g_q        <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      nxt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      m_start_q  <= 1'b0;
      m_stop_q   <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      nxt_q      <= nxt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      m_start_q  <= m_start_d;
      m_stop_q   <= m_stop_d;
      m_rw_q     <= m_rw_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    g_d        = g_q;
    rr_d       = rr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          g_d        = pick_idx;
          byte_cnt_d = (pick_len == '0) ? LEN_W'(1) : pick_len;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(ADDR_PHASE_CYCLES - 1);
        state_d = HDR;
      end
      HDR: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(BYTE_PHASE_CYCLES - 1);
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (byte_cnt_q > LEN_W'(1)) begin
          byte_cnt_d = byte_cnt_q - 1'b1;
          cnt_d      = CNT_W'(BYTE_PHASE_CYCLES - 1);
        end else begin
          cnt_d   = CNT_W'(STOP_CYCLES - 1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rr_d    = (FIXED_PRIO || g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_d     = gnt_q;
    nxt_d     = '0;
    done_d    = '0;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (state_q == IDLE && pick_any) begin
      gnt_d     = pick_onehot;
      nxt_d     = pick_onehot;
      m_rw_d    = req_rw[pick_idx];
      m_addr_d  = req_addr[pick_idx*7 +: 7];
      m_wdata_d = req_wdata[pick_idx*8 +: 8];
    end else if (state_q == DATA && cnt_q == '0 && byte_cnt_q > LEN_W'(1)) begin
      m_wdata_d = req_wdata[g_q*8 +: 8];
      nxt_d     = gnt_q;
    end else if (state_q == STOP && cnt_q == '0) begin
      done_d = gnt_q;
      gnt_d  = '0;
    end
    m_start_d = (state_d == START);
    m_stop_d  = (state_d == STOP) || (state_d == DATA && byte_cnt_d == LEN_W'(1));
    busy_d    = (state_d != IDLE);
  end

  assign gnt     = gnt_q;
  assign nxt     = nxt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign m_start = m_start_q;
  assign m_stop  = m_stop_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench: transaction-level arbitration model feeds an expected queue; a
// monitor checks every granted transaction against the cycle-timing formulas.
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [4*N-1:0] req_len;
  logic [N-1:0]   gnt, nxt, done;
  logic           busy, m_start, m_stop, m_rw;
  logic [6:0]     m_addr;
  logic [7:0]     m_wdata;

  i2c_master_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .gnt       (gnt),
    .nxt       (nxt),
    .done      (done),
    .busy      (busy),
    .m_start   (m_start),
    .m_stop    (m_stop),
    .m_rw      (m_rw),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic             rw;
    logic [6:0]       addr;
    int               len;
    logic [15:0][7:0] bytes;
    bit               b2b;
  } txn_t;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Requester agents and model state.
  logic [15:0][7:0] a_data [N];
  logic             a_rw   [N];
  logic [6:0]       a_addr [N];
  int               a_len  [N];
  int               a_raw  [N];
  int               a_rem  [N];
  int               a_ptr  [N];
  int               m_rr = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  // Model: pending requesters are served one transaction at a time by round-robin
  // (or lowest index), each repeating until its repeat count is used up.
  task automatic model_batch(input bit [N-1:0] set, input bit late);
    bit [N-1:0] pend;
    int rem [N];
    int g;
    bit first;
    txn_t t;
    pend = set;
    first = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = a_rem[i];
    while (pend != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
        if (g < 0 && pend[k]) g = k;
`else
        if (g < 0 && pend[(m_rr + k) % N]) g = (m_rr + k) % N;
`endif
      end
      t.idx = g; t.rw = a_rw[g]; t.addr = a_addr[g]; t.len = a_len[g];
      t.bytes = a_data[g]; t.b2b = !first || late;
      exp_q.push_back(t);
      rem[g]--;
      if (rem[g] == 0) pend[g] = 1'b0;
`ifdef I2C_ARB_FIXED_PRIO_EN
      m_rr = 0;
`else
      m_rr = (g + 1) % N;
`endif
      first = 1'b0;
    end
  endtask

  task automatic cfg(input int i, input logic rw, input logic [6:0] addr, input int raw,
                     input int reps, input logic [15:0][7:0] d);
    a_rw[i] = rw; a_addr[i] = addr; a_raw[i] = raw; a_len[i] = (raw == 0) ? 1 : raw;
    a_rem[i] = reps; a_ptr[i] = 0; a_data[i] = d;
  endtask

  task automatic issue(input bit [N-1:0] set, input bit late);
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        req_rw[i] = a_rw[i];
        req_addr[7*i +: 7] = a_addr[i];
        req_len[4*i +: 4] = 4'(a_raw[i]);
        req_wdata[8*i +: 8] = a_data[i][0];
        req[i] = 1'b1;
      end
    end
    model_batch(set, late);
  endtask

  // One cycle; agents react to done/nxt seen at the negedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        a_rem[i]--;
        a_ptr[i] = 0;
        if (a_rem[i] <= 0) req[i] = 1'b0;
      end else if (nxt[i] && a_ptr[i] < 15) begin
        a_ptr[i]++;
      end
      req_wdata[8*i +: 8] = a_data[i][a_ptr[i]];
    end
  endtask

  bit in_txn = 1'b0;

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_txn || req != '0) && k < budget) begin
      tick();
      k++;
    end
    check("drain_timeout", 32'(k < budget), 32'd1);
    repeat (2) tick();
  endtask

  // Monitor: pops one expected transaction per grant and checks its timeline.
  initial begin : monitor
    txn_t cur;
    int   off, done_off, nxt_cnt, start_cnt, stop_cnt, hold_err, since_done;
    logic prev_stop;
    since_done = 1000;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn = 1'b0;
        since_done = 1000;
      end else begin
        since_done++;
        if (!in_txn) begin
          if (done != '0) check("stray_done", 32'(done), 32'd0);
          if (gnt != '0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_grant", 32'(gnt), 32'd0);
            end else begin
              cur = exp_q.pop_front();
              check("gnt", 32'(gnt), 32'(1 << cur.idx));
              check("m_rw", 32'(m_rw), 32'(cur.rw));
              check("m_addr", 32'(m_addr), 32'(cur.addr));
              check("m_start_at_grant", 32'(m_start), 32'd1);
              if (cur.b2b) check("idle_gap", 32'(since_done), 32'd1);
              in_txn = 1'b1;
              off = 0; nxt_cnt = 0; start_cnt = 0; stop_cnt = 0; hold_err = 0;
              prev_stop = 1'b0;
              done_off = 21 + 9 * (cur.len - 1);
            end
          end
        end
        if (in_txn) begin
          nxt_cnt += int'(nxt[cur.idx]);
          start_cnt += int'(m_start);
          stop_cnt += int'(m_stop);
          if (off >= 10 && (off - 10) % 9 == 0 && (off - 10) / 9 < cur.len)
            check("m_wdata", 32'(m_wdata), 32'(cur.bytes[(off - 10) / 9]));
          if (off == 10 + 9 * (cur.len - 1))
            check("m_stop_rise", 32'({prev_stop, m_stop}), 32'b01);
          if (off < done_off) begin
            if (done != '0 || !busy || gnt != N'(1 << cur.idx) || m_rw != cur.rw ||
                m_addr != cur.addr) hold_err++;
          end else begin
            check("done", 32'(done), 32'(1 << cur.idx));
            check("nxt_count", 32'(nxt_cnt), 32'(cur.len));
            check("start_count", 32'(start_cnt), 32'd1);
            check("stop_count", 32'(stop_cnt), 32'd11);
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("hold_during_txn", 32'(hold_err), 32'd0);
            in_txn = 1'b0;
            since_done = 0;
          end
          prev_stop = m_stop;
          off++;
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0][7:0] d;
    bit [N-1:0] set;
    reset = 1'b1;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0; req_len = '0;
    for (int i = 0; i < N; i++) begin
      a_rem[i] = 0; a_ptr[i] = 0; a_data[i] = '0; a_rw[i] = 1'b0; a_addr[i] = '0;
      a_len[i] = 1; a_raw[i] = 1;
    end
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'({m_start, m_stop, m_rw, nxt, done}), 32'd0);
    check("rst_data", 32'({m_addr, m_wdata}), 32'd0);
    reset = 1'b0;
    tick();

    // Single write to 0x50.
    d = '0; d[0] = 8'hA5;
    cfg(1, 1'b0, 7'h50, 1, 1, d);
    issue(4'b0010, 1'b0);
    wait_idle(200);

    // Three-byte write advanced by nxt.
    d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    cfg(0, 1'b0, 7'h21, 3, 1, d);
    issue(4'b0001, 1'b0);
    wait_idle(200);

    // All four held for two transactions each.
    for (int i = 0; i < N; i++) begin
      d = '0; d[0] = 8'(8'h40 + i);
      cfg(i, 1'(i), 7'(7'h10 + i), 1, 2, d);
    end
    issue(4'b1111, 1'b0);
    wait_idle(1000);

    // Late request while requester 0 is busy.
    d = '0; d[0] = 8'h5A; d[1] = 8'hC3;
    cfg(0, 1'b1, 7'h33, 2, 1, d);
    issue(4'b0001, 1'b0);
    repeat (5) tick();
    d = '0; d[0] = 8'h77;
    cfg(2, 1'b0, 7'h44, 0, 1, d);
    issue(4'b0100, 1'b1);
    wait_idle(400);

    // Two held requesters, one with repeats.
    d = '0; d[0] = 8'h99;
    cfg(1, 1'b0, 7'h61, 1, 3, d);
    cfg(3, 1'b1, 7'h63, 1, 1, d);
    issue(4'b1010, 1'b0);
    wait_idle(600);

    // Reset in the middle of DATA: no done, outputs cleared, clean restart.
    d = '0; d[0] = 8'hE1; d[1] = 8'hE2;
    cfg(3, 1'b0, 7'h7F, 2, 1, d);
    issue(4'b1000, 1'b0);
    repeat (16) tick();
    reset = 1'b1;
    req = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) a_rem[i] = 0;
    m_rr = 0;
    repeat (3) begin
      tick();
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_busy_start_done", 32'({busy, m_start, done}), 32'd0);
    end
    reset = 1'b0;
    repeat (2) begin
      tick();
      check("post_rst_idle", 32'({gnt, done, busy}), 32'd0);
    end
    d = '0; d[0] = 8'h3C;
    cfg(2, 1'b0, 7'h2A, 1, 1, d);
    issue(4'b0100, 1'b0);
    wait_idle(200);

    // Random batches.
    for (int b = 0; b < 20; b++) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (set[i]) begin
          for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
          cfg(i, 1'($urandom), 7'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 2)), d);
        end
      end
      issue(set, 1'b0);
      wait_idle(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
